pipe_skid_rx: RTL

PIPE_SKID_RX -- requirements
Module: pipe_skid_rx

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_data_reg.sv | 33 +++
 rtl/pipe_skid_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipe_skid_rx receive skid buffer.
//   pipe_state_t   : occupancy state of the skid buffer (EMPTY / ONE / TWO)
//   PIPE_WIDTH_DEF : default payload width
//   STALL_CNT_W    : width of the optional stall counter
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int STALL_CNT_W    = 16;

endpackage

// File: rtl/pipe_data_reg.sv
// -----------------------------------------------------------------------------
// pipe_data_reg
// WIDTH-bit payload register with load enable and no reset. The payload only
// matters when the surrounding control says it is valid, so it is left
// uninitialised.
// Ports:
//   clock  : rising-edge clock
//   load_i : capture d_i on this edge
//   d_i    : next payload
//   q_o    : held payload (directly from the flops)
// -----------------------------------------------------------------------------
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clock) begin
        if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_rx.sv
// -----------------------------------------------------------------------------
// pipe_skid_rx
// Two-entry skid buffer between a registered upstream producer and a
// downstream consumer. in_ready, out_valid and out_data all come straight
// from flops, so no combinational path crosses the block in either direction.
// Full throughput is kept with out_ready high; when the consumer stalls, the
// word already in flight from upstream lands in the skid register.
//
// Optional build macro: PIPE_SKID_STATS_EN adds the stall_count port, a
// saturating count of cycles with out_valid=1 and out_ready=0.
//
// Ports:
//   clock       : rising-edge clock
//   reset       : synchronous, active-high reset (control only)
//   in_valid    : upstream word present
//   in_data     : upstream payload
//   in_ready    : block can accept (registered)
//   out_valid   : out_data holds a valid word (registered)
//   out_data    : payload from the main register
//   out_ready   : downstream accepts
//   stall_count : saturating stall counter (PIPE_SKID_STATS_EN only)
// -----------------------------------------------------------------------------
module pipe_skid_rx
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    pipe_state_t      state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Data-path load enables. Gated by reset so nothing moves while the
    // control is being cleared.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        if (!reset) begin
            case (state_q)
                EMPTY: main_load = in_fire;
                ONE: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & ~out_fire;
                end
                TWO: begin
                    // Draining: the skid word moves up into main.
                    main_load = out_fire;
                    main_d    = skid_q;
                end
                default: begin
                    main_load = 1'b0;
                    skid_load = 1'b0;
                end
            endcase
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clock  (clock),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clock  (clock),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    // Occupancy FSM. in_ready and out_valid are registered from the next
    // state: in_ready = (next != TWO), out_valid = (next != EMPTY).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_q     <= TWO;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_q     <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                TWO: begin
                    out_valid_q <= 1'b1;
                    if (out_fire) begin
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_count = stall_q;
`endif

endmodule
